// File: rtl/decode_ctrl_pkg.sv
// decode_ctrl_pkg: FSM state encoding, ALU/multiply command codes and flag-write codes
package decode_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI,
        ALUWB, BRANCH, MULX, MULWB_LO, MULWB_HI
    } state_t;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_ORR  = 3'b011;
    localparam logic [2:0] ALU_MUL  = 3'b111;
    localparam logic [2:0] ALU_SMUL = 3'b110;
    localparam logic [2:0] ALU_UMUL = 3'b101;
    localparam logic [3:0] CMD_ADD  = 4'b0100;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_AND  = 4'b0000;
    localparam logic [3:0] CMD_ORR  = 4'b1100;
    localparam logic [3:0] CMD_MUL  = 4'b1001;
    localparam logic [3:0] CMD_SMUL = 4'b1101;
    localparam logic [3:0] CMD_UMUL = 4'b1111;
    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;
    function automatic logic is_mul(input logic [3:0] cmd);
        return cmd == CMD_MUL || cmd == CMD_SMUL || cmd == CMD_UMUL;
    endfunction
    function automatic logic [2:0] alu_dec(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB:  return ALU_SUB;
            CMD_AND:  return ALU_AND;
            CMD_ORR:  return ALU_ORR;
            CMD_MUL:  return ALU_MUL;
            CMD_SMUL: return ALU_SMUL;
            CMD_UMUL: return ALU_UMUL;
            default:  return ALU_ADD;
        endcase
    endfunction
    function automatic logic [1:0] flag_dec(input logic [3:0] cmd, input logic s);
        return !s ? FLAGW_NONE :
               (cmd == CMD_ADD || cmd == CMD_SUB) ? FLAGW_ALL :
               (cmd == CMD_AND || cmd == CMD_ORR || is_mul(cmd)) ? FLAGW_NZ : FLAGW_NONE;
    endfunction
endpackage

// File: rtl/decode_ctrl_mul_lat_counter.sv
// mul_lat_counter: loadable down-counter with zero flag timing multiply execution
module mul_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (load) cnt <= value;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: multicycle instruction-decode FSM with multi-cycle multiply.
// DECODE_CTRL_LONGMUL_EN adds a second (RdHi) write-back for SMUL/UMUL.
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       MemReady,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic       WrHi,
    output logic       Busy
);
    localparam int CW = $clog2(MUL_LAT) + 1;
    if (MUL_LAT < 1 || MUL_LAT > 16) begin : g_bad_lat
        $error("decode_ctrl: MUL_LAT must be in 1..16");
    end
    state_t state, next;
    logic [3:0] cmd;
    logic cnt_zero, ir_w, reg_w, mem_w, busy, branch, alu_st, flag_st;
    assign cmd = Funct[4:1];
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= FETCH;
        else state <= next;
    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = MemReady ? DECODE : FETCH;
            DECODE:   next = Op == 2'b01 ? MEMADR : Op == 2'b10 ? BRANCH : Op == 2'b11 ? FETCH :
                             Funct[5] ? EXECI : is_mul(cmd) ? MULX : EXECR;
            MEMADR:   next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    next = MemReady ? MEMWB : MEMRD;
            MEMWR:    next = MemReady ? FETCH : MEMWR;
            EXECR:    next = ALUWB;
            EXECI:    next = ALUWB;
            MULX:     next = cnt_zero ? MULWB_LO : MULX;
`ifdef DECODE_CTRL_LONGMUL_EN
            MULWB_LO: next = cmd == CMD_MUL ? FETCH : MULWB_HI;
`endif
            default:  next = FETCH;
        endcase
    end
    // Loaded on the DECODE->MULX edge so MULX lasts exactly MUL_LAT cycles
    mul_lat_counter #(.W(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (state == DECODE && next == MULX),
        .dec   (state == MULX),
        .value (CW'(MUL_LAT - 1)),
        .zero  (cnt_zero)
    );
`ifdef DECODE_CTRL_LONGMUL_EN
    logic wr_hi;
    assign wr_hi = state == MULWB_HI;
    assign WrHi = reset & wr_hi;
`else
    assign WrHi = 1'b0;
`endif
    always_comb begin
        {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB} = '0;
        {ir_w, reg_w, mem_w, busy, branch, alu_st, flag_st} = '0;
        case (state)
            FETCH:    begin ir_w = MemReady; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            DECODE:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            MEMADR:   ALUSrcB = 2'b01;
            MEMRD:    AdrSrc = 1'b1;
            MEMWB:    begin ResultSrc = 2'b01; reg_w = 1'b1; end
            MEMWR:    begin AdrSrc = 1'b1; mem_w = 1'b1; end
            EXECR:    begin alu_st = 1'b1; flag_st = 1'b1; end
            EXECI:    begin ALUSrcB = 2'b01; alu_st = 1'b1; flag_st = 1'b1; end
            ALUWB:    reg_w = 1'b1;
            BRANCH:   begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
            MULX:     begin alu_st = 1'b1; busy = 1'b1; end
            MULWB_LO: begin reg_w = 1'b1; alu_st = 1'b1; flag_st = 1'b1; end
            MULWB_HI: reg_w = 1'b1;
            default:  ;
        endcase
    end
    // Write/flag strobes are suppressed while reset is held, even in FETCH
    assign IRWrite    = reset & ir_w;
    assign NextPC     = reset & ir_w;
    assign RegW       = reset & reg_w;
    assign MemW       = reset & mem_w;
    assign Busy       = reset & busy;
    assign FlagW      = (reset & flag_st) ? flag_dec(cmd, Funct[0]) : FLAGW_NONE;
    assign ALUControl = alu_st ? alu_dec(cmd) : ALU_ADD;
    assign PCS        = ((Rd == 4'd15) & RegW) | (reset & branch);
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};
endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have parameter: MUL_LAT, 4, multiply execute cycles (legal range 1..16; out of range SHALL be an elaboration error).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Op  in  2  instruction class
- Funct  in  6  function field: [5]=I, [4:1]=cmd, [0]=S/L
- Rd  in  4  destination register
- MemReady  in  1  memory access complete this cycle
- FlagW  out  2  flag-write enables {NZ,CV}
- PCS  out  1  PC written by branch or by a register write to R15
- NextPC  out  1  PC increment enable
- RegW  out  1  register-file write enable
- MemW  out  1  memory write enable
- IRWrite  out  1  instruction register load
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- ResultSrc  out  2  result mux select
- ALUSrcA  out  1  ALU A select
- ALUSrcB  out  2  ALU B select
- ImmSrc  out  2  immediate format
- RegSrc  out  2  register-address selects
- ALUControl  out  3  ALU operation
- WrHi  out  1  write-back targets RdHi (long multiply)
- Busy  out  1  multiply in progress

Function
REQ-003 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, MULX, MULWB_LO, MULWB_HI.
REQ-004 FETCH behaviour:
- outputs: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=NextPC=MemReady
- stays in FETCH while MemReady=0; moves to DECODE on MemReady=1
REQ-005 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10, and SHALL branch on the decoded class:
- Op=01 -> MEMADR
- Op=10 -> BRANCH
- Op=00, Funct[5]=1 -> EXECI
- Op=00, Funct[5]=0, cmd in {1001,1101,1111} -> MULX
- Op=00, Funct[5]=0, any other cmd -> EXECR
- Op=11 -> FETCH, with no writes
REQ-006 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, ADD; then MEMRD if Funct[0]=1, else MEMWR.
REQ-007 Memory states SHALL behave as follows:
- MEMRD: AdrSrc=1; waits for MemReady, then MEMWB
- MEMWB: ResultSrc=01, RegW=1; then FETCH
- MEMWR: AdrSrc=1; MemW=1 held every cycle until MemReady=1; then FETCH
REQ-008 ALU states SHALL behave as follows:
- EXECR: ALUSrcA=0, ALUSrcB=00
- EXECI: ALUSrcA=0, ALUSrcB=01
- both apply ALU decode and go to ALUWB
- ALUWB: ResultSrc=00, RegW=1; then FETCH
REQ-009 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ResultSrc=10, internal Branch=1; then FETCH.
REQ-010 MULX SHALL behave as follows:
- outputs: ALUSrcA=0, ALUSrcB=00, ALU decode, Busy=1
- down-counter loaded with MUL_LAT-1 on entry from DECODE, decrements each cycle
- exits to MULWB_LO in the cycle the counter reads 0
- total MULX residency SHALL equal exactly MUL_LAT cycles
REQ-011 MULWB_LO SHALL drive ResultSrc=00 and RegW=1, hold ALU decode, and apply FlagW; then MULWB_HI or FETCH (REQ-019).
REQ-012 MULWB_HI SHALL drive RegW=1, WrHi=1, ResultSrc=00; then FETCH.
REQ-013 ALU decode (Funct[4:1] -> ALUControl) SHALL map:
- 0100 -> 000 ADD
- 0010 -> 001 SUB
- 0000 -> 010 AND
- 1100 -> 011 ORR
- 1001 -> 111 MUL
- 1101 -> 110 SMUL
- 1111 -> 101 UMUL
- default -> 000
- outside ALU-decode states ALUControl SHALL be 000
REQ-014 FlagW SHALL be non-zero only in EXECR, EXECI and MULWB_LO, and only when Funct[0]=1:
- ADD/SUB -> 11
- AND/ORR/multiplies -> 10
- at most one flag-write cycle per instruction
REQ-015 Combinational outputs SHALL be:
- PCS = ((Rd==15) & RegW) | Branch
- ImmSrc = Op
- RegSrc[0] = (Op==10)
- RegSrc[1] = (Op==01)
REQ-016 Any control output not listed for a state SHALL be 0.

Reset
REQ-017 reset=0 SHALL asynchronously force state=FETCH and counter=0, at any point including mid-MULX and mid-MEMWR.
REQ-018 While reset=0, IRWrite, NextPC, RegW, MemW, PCS, Busy, WrHi and FlagW SHALL be 0, regardless of MemReady.

Configuration
REQ-019 Macro DECODE_CTRL_LONGMUL_EN:
- defined: SMUL/UMUL take MULWB_LO then MULWB_HI (two register writes); MUL skips MULWB_HI
- undefined: MULWB_HI SHALL be absent, WrHi tied 0, all multiplies return FETCH after MULWB_LO

Structure
REQ-020 Package decode_ctrl_pkg SHALL hold the state enum, ALUControl codes, multiply cmd codes and FlagW codes.
REQ-021 Sub-module mul_lat_counter (load, decrement, zero flag, width $clog2(MUL_LAT)+1) SHALL be instantiated once.

Verification
REQ-022 ADD R1 (Op=00, Funct=001001), MemReady=1 -> FETCH,DECODE,EXECR,ALUWB; FlagW=11 in EXECR only; RegW=1 in ALUWB.
REQ-023 LDR (Op=01, Funct[0]=1), MemReady low 3 cycles in MEMRD -> MEMRD held 4 cycles; RegW=1 once, in MEMWB.
REQ-024 UMUL (Funct[4:1]=1111), MUL_LAT=4 -> Busy=1 for exactly 4 cycles; WrHi=1 in the second write-back (macro on), absent (macro off).
REQ-025 ORR with Rd=15, S=1 -> PCS=1 in ALUWB; FlagW=10 in EXECR.
REQ-026 reset pulled low in 2nd MULX cycle, then released -> next cycle FETCH, Busy=0, no RegW pulse.
